// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
//
// Pays out a change amount as physical coins (50/10/5/1) through a pulse-driven
// coin ejector, picking the largest coin that still fits on every step. Each
// coin is one strobe of PULSE_CYCLES clocks followed by a wait for the ejector
// acknowledge; a missing acknowledge parks the block in FAULT until cleared.
//
// Optional feature macro: COIN_INVENTORY_EN
//   When defined, a per-denomination coin count limits which coins may be
//   chosen, a refill port adds coins (saturating at 255) and inv_empty reports
//   the empty denominations. When undefined, supply is unlimited.
//
// Parameters
//   PULSE_CYCLES  width of each eject_pulse in clk cycles (1..15)
//   ACK_TIMEOUT   cycles to wait for eject_ack after a pulse ends (1..255)
//
// Ports
//   clk           clock
//   reset         asynchronous, active-high reset
//   req_valid     change request (may be a single-cycle pulse)
//   req_amount    change amount in coin units
//   req_ready     high only while idle
//   eject_sel     one-hot coin select {50,10,5,1}, held through PULSE/WAIT_ACK
//   eject_pulse   ejector strobe, PULSE_CYCLES cycles per coin
//   eject_ack     ejector confirms one coin dropped (level or pulse)
//   busy          high in every state except IDLE
//   done          single-cycle pulse when a payout completes
//   paid_total    coins paid for the current/last request, cleared on accept
//   req_lost      sticky: a request arrived while not ready
//   fault         high while parked in FAULT
//   fault_clr     clears fault and req_lost, FAULT -> IDLE
//   refill_valid  (inventory) add refill_count coins of refill_sel
//   refill_sel    (inventory) 0:1 1:5 2:10 3:50
//   refill_count  (inventory) number of coins added
//   inv_empty     (inventory) per-denomination empty flags {50,10,5,1}
// -----------------------------------------------------------------------------
module change_dispenser #(
   parameter int unsigned PULSE_CYCLES = 4,
   parameter int unsigned ACK_TIMEOUT  = 200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   input  logic [7:0] req_amount,
   output logic       req_ready,
   output logic [3:0] eject_sel,
   output logic       eject_pulse,
   input  logic       eject_ack,
   output logic       busy,
   output logic       done,
   output logic [7:0] paid_total,
   output logic       req_lost,
   output logic       fault,
   input  logic       fault_clr
`ifdef COIN_INVENTORY_EN
   ,
   input  logic       refill_valid,
   input  logic [1:0] refill_sel,
   input  logic [7:0] refill_count,
   output logic [3:0] inv_empty
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_PULSE,
      S_WAIT_ACK,
      S_DONE,
      S_FAULT
   } state_t;

   localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);
   localparam logic [7:0] ACK_LAST   = 8'(ACK_TIMEOUT - 1);

   // Largest coin not exceeding amt among the denominations flagged in avail.
   function automatic logic [3:0] pick_coin(input logic [7:0] amt,
                                            input logic [3:0] avail);
      logic [3:0] sel;
      sel = 4'b0000;
      if (avail[3] && amt >= 8'd50)      sel = 4'b1000;
      else if (avail[2] && amt >= 8'd10) sel = 4'b0100;
      else if (avail[1] && amt >= 8'd5)  sel = 4'b0010;
      else if (avail[0] && amt >= 8'd1)  sel = 4'b0001;
      return sel;
   endfunction

   function automatic logic [7:0] coin_value(input logic [3:0] sel);
      logic [7:0] val;
      case (sel)
         4'b1000: val = 8'd50;
         4'b0100: val = 8'd10;
         4'b0010: val = 8'd5;
         4'b0001: val = 8'd1;
         default: val = 8'd0;
      endcase
      return val;
   endfunction

   state_t     state, state_next;
   logic [7:0] remaining;
   logic [3:0] coin_sel;
   logic [3:0] pulse_cnt;
   logic [7:0] wait_cnt;
   logic       ack_seen;
   logic [3:0] coin_avail;
   logic [3:0] coin_pick;
   logic [7:0] coin_val;

   // Control strobes from the FSM to the datapath.
   logic       accept;
   logic       load_coin;
   logic       coin_paid;

   assign coin_pick = pick_coin(remaining, coin_avail);
   assign coin_val  = coin_value(coin_sel);

   // --------------------------------------------------------------------------
   // Coin supply
   // --------------------------------------------------------------------------
`ifdef COIN_INVENTORY_EN
   logic [7:0] coin_cnt [4];

   // Count after an optional single-coin decrement and an optional saturating
   // refill in the same cycle. A decrement only happens on a coin that was
   // selected with a non-zero count, so cnt - dec never wraps.
   function automatic logic [7:0] inv_next(input logic [7:0] cnt,
                                           input logic       dec,
                                           input logic       add,
                                           input logic [7:0] amt);
      logic [8:0] sum;
      sum = {1'b0, cnt} - {8'd0, dec} + (add ? {1'b0, amt} : 9'd0);
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

   // NOTE: the counts are individual registers with a defined reset value,
   // not a RAM, so clearing them in the reset branch is both legal and cheap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) coin_cnt[i] <= 8'd0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            coin_cnt[i] <= inv_next(coin_cnt[i],
                                    coin_paid && coin_sel[i],
                                    refill_valid && (refill_sel == 2'(i)),
                                    refill_count);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) inv_empty[i] = (coin_cnt[i] == 8'd0);
   end

   assign coin_avail = ~inv_empty;
`else
   assign coin_avail = 4'b1111;
`endif

   // --------------------------------------------------------------------------
   // FSM state register
   // --------------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // --------------------------------------------------------------------------
   // FSM next state and outputs
   // --------------------------------------------------------------------------
   // NOTE: every signal written here gets a default first; a path that leaves
   // one unassigned would infer a latch.
   always_comb begin
      state_next  = state;
      accept      = 1'b0;
      load_coin   = 1'b0;
      coin_paid   = 1'b0;
      req_ready   = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      fault       = 1'b0;
      eject_pulse = 1'b0;
      eject_sel   = 4'b0000;

      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) begin
               accept     = 1'b1;
               state_next = S_SELECT;
            end
         end

         S_SELECT: begin
            if (remaining == 8'd0) begin
               state_next = S_DONE;
            end else if (coin_pick == 4'b0000) begin
               // Only reachable with a limited inventory: change is owed but
               // no denomination that fits is in stock.
               state_next = S_FAULT;
            end else begin
               load_coin  = 1'b1;
               state_next = S_PULSE;
            end
         end

         S_PULSE: begin
            eject_pulse = 1'b1;
            eject_sel   = coin_sel;
            // The strobe always runs full width; an ack that arrived during
            // it lets us skip WAIT_ACK.
            if (pulse_cnt == PULSE_LAST) begin
               if (ack_seen || eject_ack) begin
                  coin_paid  = 1'b1;
                  state_next = S_SELECT;
               end else begin
                  state_next = S_WAIT_ACK;
               end
            end
         end

         S_WAIT_ACK: begin
            eject_sel = coin_sel;
            if (eject_ack) begin
               coin_paid  = 1'b1;
               state_next = S_SELECT;
            end else if (wait_cnt == ACK_LAST) begin
               state_next = S_FAULT;
            end
         end

         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end

         S_FAULT: begin
            fault = 1'b1;
            if (fault_clr) state_next = S_IDLE;
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Datapath: amount bookkeeping, coin register, timers, sticky flags
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         remaining  <= 8'd0;
         paid_total <= 8'd0;
         coin_sel   <= 4'b0000;
         pulse_cnt  <= 4'd0;
         wait_cnt   <= 8'd0;
         ack_seen   <= 1'b0;
         req_lost   <= 1'b0;
      end else begin
         if (accept) begin
            remaining  <= req_amount;
            paid_total <= 8'd0;
         end else if (coin_paid) begin
            // coin_val <= remaining by construction of the selection.
            remaining  <= remaining - coin_val;
            paid_total <= paid_total + coin_val;
         end

         if (load_coin) coin_sel <= coin_pick;

         // Both timers restart from zero whenever their state is entered,
         // because they are held at zero in every other state.
         pulse_cnt <= (state == S_PULSE)    ? pulse_cnt + 4'd1 : 4'd0;
         wait_cnt  <= (state == S_WAIT_ACK) ? wait_cnt + 8'd1  : 8'd0;

         // Acks are only remembered while the strobe is running, so repeated
         // acks for one coin collapse into one.
         ack_seen <= (state == S_PULSE) ? (ack_seen | eject_ack) : 1'b0;

         // A clear in the same cycle as a stray request wins.
         if (fault_clr)                           req_lost <= 1'b0;
         else if (req_valid && state != S_IDLE)   req_lost <= 1'b1;
      end
   end

endmodule
